// File: rtl/ru_drain.sv
// rtl/ru_drain.sv - result collector for the Q8.8 softmax reduction unit: FWFT FIFO, vector framing.
// Optional per-vector out_1 sum under RU_DRAIN_SUM_EN.
module ru_drain #(
   parameter int DEPTH   = 8,
   parameter int VEC_LEN = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ru_valid_out,
   input  logic [15:0] ru_out_0,
   input  logic [15:0] ru_out_1,
   output logic        ru_en,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,
   output logic        vec_done,
   output logic [23:0] sum_out,
   output logic        sum_valid
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [IW-1:0] idx;
   logic          push;
   logic          pop;
   logic          push_last;

   // ru_en depends only on registered count, so m_ready never reaches the unit combinationally
   assign ru_en     = (count != (AW+1)'(DEPTH));
   assign m_valid   = (count != '0);
   assign push      = ru_valid_out && ru_en;
   assign pop       = m_valid && m_ready;
   assign push_last = (idx == IW'(VEC_LEN - 1));
   assign m_data    = mem[rd_ptr][31:0];
   assign m_last    = m_valid && mem[rd_ptr][32];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {push_last, ru_out_0, ru_out_1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         idx      <= '0;
         vec_done <= 1'b0;
      end else begin
         vec_done <= pop && mem[rd_ptr][32];
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            idx    <= push_last ? '0 : idx + IW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef RU_DRAIN_SUM_EN
   logic [23:0] acc;
   logic [24:0] acc_next;
   logic [23:0] acc_sat;

   assign acc_next = {1'b0, acc} + {9'd0, ru_out_1};
   assign acc_sat  = acc_next[24] ? 24'hFFFFFF : acc_next[23:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         sum_out   <= '0;
         sum_valid <= 1'b0;
      end else begin
         sum_valid <= push && push_last;
         if (push) begin
            if (push_last) begin
               acc     <= '0;
               sum_out <= acc_sat;
            end else begin
               acc <= acc_sat;
            end
         end
      end
   end
`else
   assign sum_out   = '0;
   assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ru_drain.sv
// tb/tb_ru_drain.sv - directed self-checking bench for ru_drain (DEPTH=8, VEC_LEN=4).
// Sum checks follow RU_DRAIN_SUM_EN.
module tb_ru_drain;
   logic        clk = 1'b0;
   logic        rst;
   logic        ru_valid_out;
   logic [15:0] ru_out_0;
   logic [15:0] ru_out_1;
   logic        ru_en;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;
   logic        vec_done;
   logic [23:0] sum_out;
   logic        sum_valid;

   int checks = 0;
   int errors = 0;

   ru_drain #(.DEPTH(8), .VEC_LEN(4)) dut (
      .clk(clk), .rst(rst), .ru_valid_out(ru_valid_out), .ru_out_0(ru_out_0),
      .ru_out_1(ru_out_1), .ru_en(ru_en), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .vec_done(vec_done), .sum_out(sum_out),
      .sum_valid(sum_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ru_valid_out = 1'b0;
      ru_out_0 = '0;
      ru_out_1 = '0;
      m_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] item(input int k);
      return {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
   endfunction

   initial begin
      int pushed;
      int popped;
      int lasts;
      int vdones;
      logic [32:0] q[$];
      logic [32:0] head;

      // reset values
      do_reset();
      chk("rst_ru_en", ru_en, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_vec_done", vec_done, 0);
      chk("rst_sum_valid", sum_valid, 0);
      chk("rst_sum_out", sum_out, 0);

      // single push latency
      m_ready = 1'b1;
      chk("lat_pre_valid", m_valid, 0);
      ru_valid_out = 1'b1; ru_out_0 = 16'h0100; ru_out_1 = 16'h0080;
      step();
      ru_valid_out = 1'b0;
      chk("lat_valid", m_valid, 1);
      chk("lat_data", m_data, 32'h01000080);
      chk("lat_last", m_last, 0);
      step();
      chk("lat_gone", m_valid, 0);

      // backpressure fill, held item, drain order
      do_reset();
      for (int k = 0; k < 8; k++) begin
         ru_valid_out = 1'b1;
         {ru_out_0, ru_out_1} = item(k);
         chk("fill_en", ru_en, 1);
         step();
      end
      chk("full_en", ru_en, 0);
      chk("full_valid", m_valid, 1);
      {ru_out_0, ru_out_1} = item(8);
      step();
      step();
      chk("stall_en", ru_en, 0);
      chk("stall_head", m_data, item(0));
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("after_pop_en", ru_en, 1);
      chk("after_pop_head", m_data, item(1));
      step();
      ru_valid_out = 1'b0;
      chk("refull_en", ru_en, 0);
      m_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         chk("drain_valid", m_valid, 1);
         chk("drain_data", m_data, item(k));
         chk("drain_last", m_last, ((k % 4) == 3) ? 1 : 0);
         chk("drain_vdone", vec_done, ((k % 4) == 0) ? 1 : 0);
         step();
      end
      chk("drain_empty", m_valid, 0);
      chk("drain_vdone_end", vec_done, 0);

      // framing with toggling m_ready
      do_reset();
      pushed = 0; popped = 0; lasts = 0; vdones = 0;
      q.delete();
      for (int cyc = 0; cyc < 60 && popped < 8; cyc++) begin
         ru_valid_out = (pushed < 8);
         ru_out_0 = 16'h0A00 + 16'(pushed);
         ru_out_1 = 16'h0B00 + 16'(pushed);
         m_ready = cyc[0];
         if (m_valid && m_ready) begin
            head = q.pop_front();
            chk("frm_data", m_data, head[31:0]);
            chk("frm_last", m_last, head[32]);
            if (m_last) lasts++;
            popped++;
         end
         if (ru_valid_out && ru_en) begin
            q.push_back({(pushed % 4) == 3, ru_out_0, ru_out_1});
            pushed++;
         end
         step();
         if (vec_done) vdones++;
      end
      ru_valid_out = 1'b0;
      chk("frm_popped", popped, 8);
      chk("frm_lasts", lasts, 2);
      chk("frm_vdones", vdones, 2);

      // per-vector sum
      do_reset();
      m_ready = 1'b1;
      ru_valid_out = 1'b1;
      ru_out_0 = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: ru_out_1 = 16'h0100;
            1: ru_out_1 = 16'h0080;
            default: ru_out_1 = 16'h0040;
         endcase
         step();
         if (k < 3) chk("sum_no_pulse", sum_valid, 0);
      end
      ru_out_1 = 16'hFFFF;
`ifdef RU_DRAIN_SUM_EN
      chk("sum1_valid", sum_valid, 1);
      chk("sum1_out", sum_out, 32'h000200);
`else
      chk("sum1_valid", sum_valid, 0);
      chk("sum1_out", sum_out, 0);
`endif
      step();
      chk("sum1_pulse_end", sum_valid, 0);
      step();
      step();
      step();
      ru_valid_out = 1'b0;
`ifdef RU_DRAIN_SUM_EN
      chk("sum2_valid", sum_valid, 1);
      chk("sum2_out", sum_out, 32'h03FFFC);
`else
      chk("sum2_valid", sum_valid, 0);
      chk("sum2_out", sum_out, 0);
`endif
      step();
      chk("sum2_hold_valid", sum_valid, 0);
`ifdef RU_DRAIN_SUM_EN
      chk("sum2_hold", sum_out, 32'h03FFFC);
`endif

      // reset mid-operation: 5 queued, idx = 2
      do_reset();
      for (int k = 0; k < 6; k++) begin
         ru_valid_out = 1'b1;
         {ru_out_0, ru_out_1} = item(k);
         step();
      end
      ru_valid_out = 1'b0;
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("mid_valid", m_valid, 1);
      chk("mid_head", m_data, item(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_en", ru_en, 1);
      for (int k = 20; k < 24; k++) begin
         ru_valid_out = 1'b1;
         {ru_out_0, ru_out_1} = item(k);
         step();
      end
      ru_valid_out = 1'b0;
      m_ready = 1'b1;
      for (int k = 20; k < 24; k++) begin
         chk("mid_data", m_data, item(k));
         chk("mid_last", m_last, (k == 23) ? 1 : 0);
         step();
      end
      chk("mid_empty", m_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
